game_ctrl: RTL

//   Game controller that sits directly upstream of the seven-segment display driver and feeds its state[2:0]/data[7:0] inputs.

---
 rtl/game_ctrl_if.sv | 25 ++
 rtl/game_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_if.sv
// Button and display bus between the game controller and its environment.
// The slave side is the controller; the master side drives the raw buttons.
interface game_ctrl_if;
  logic       btn_start;
  logic       btn_ok;
  logic       btn_err;
  logic [2:0] state;
  logic [7:0] data;

  modport master (
    output btn_start,
    output btn_ok,
    output btn_err,
    input  state,
    input  data
  );

  modport slave (
    input  btn_start,
    input  btn_ok,
    input  btn_err,
    output state,
    output data
  );
endinterface

// File: rtl/game_ctrl.sv
// Score/lives game controller feeding the seven-segment driver, with one
// debouncer per raw push-button and a per-turn timeout.

module game_ctrl_deb #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int unsigned    CW       = $clog2(DEB_CYCLES + 2);
  localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0]  ARM_LAST = CW'(DEB_CYCLES + 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic          armed;
  logic [CW-1:0] cnt;

  // After reset the button must be seen released for DEB_CYCLES+2 samples
  // (two extra cover the cleared synchronizer) before presses are accepted,
  // so a button held across reset release never produces a pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      meta  <= btn;
      sync  <= meta;
      pulse <= 1'b0;
      if (!armed) begin
        if (sync) begin
          cnt <= '0;
        end else if (cnt == ARM_LAST) begin
          armed <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (sync == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        level <= sync;
        pulse <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module game_ctrl #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT    = 300_000_000,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned WIN_SCORE  = 10
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.slave  gc
);
  localparam logic [3:0]  LIVES_INIT = 4'(LIVES);
  localparam logic [3:0]  WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_PLAY = 3'b010,
    S_WIN  = 3'b011,
    S_LOSE = 3'b100
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  score_q, score_d;
  logic [3:0]  lives_q, lives_d;
  logic [31:0] timer_q, timer_d;
  logic        start_p, ok_p, err_p;
  logic        hit, miss;

  game_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(clk), .rst(rst), .btn(gc.btn_start), .pulse(start_p)
  );
  game_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
    .clk(clk), .rst(rst), .btn(gc.btn_ok), .pulse(ok_p)
  );
  game_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_err (
    .clk(clk), .rst(rst), .btn(gc.btn_err), .pulse(err_p)
  );

  // err beats ok, ok beats a timeout landing in the same cycle
  assign hit  = ok_p & ~err_p;
  assign miss = err_p | (~ok_p & (timer_q == TIMER_LAST));

  // State and game registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      score_q <= 4'h0;
      lives_q <= LIVES_INIT;
      timer_q <= 32'd0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_p) state_d = S_PLAY;
      S_PLAY: begin
        if (miss && lives_q <= 4'd1) begin
          state_d = S_LOSE;
        end else if (hit && score_q >= WIN_VAL - 4'd1) begin
          state_d = S_WIN;
        end
      end
      S_WIN, S_LOSE: if (start_p) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Score, lives and turn timer updates
  always_comb begin
    score_d = score_q;
    lives_d = lives_q;
    timer_d = timer_q;
    case (state_q)
      S_PLAY: begin
        if (miss) begin
          lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
          timer_d = 32'd0;
        end else if (hit) begin
          score_d = (score_q < WIN_VAL) ? score_q + 4'd1 : score_q;
          timer_d = 32'd0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_p) begin
          score_d = 4'h0;
          lives_d = LIVES_INIT;
          timer_d = 32'd0;
        end
      end
      default: begin
        score_d = 4'h0;
        lives_d = LIVES_INIT;
        timer_d = 32'd0;
      end
    endcase
  end

  assign gc.state = state_q;
  assign gc.data  = {lives_q, score_q};
endmodule
